mic_volume_meter: RTL and testbench
===================================

Name: mic_volume_meter

Overview:
- Upstream stage of the game/menu controller: converts raw microphone samples into the 5-bit `volume` level used by the mic-volume screen and the record step.
- Computes sample magnitude about midscale and tracks the peak over a fixed window of accepted samples.
- At each window end, quantises the peak to level 0..16 and issues a one-cycle update strobe.

Parameters:
- SAMPLE_W, 12, mic sample width, unsigned offset-binary; midscale = 2^(SAMPLE_W-1).
- WINDOW, 2000, accepted samples per measurement window (2..65535).
- NOISE_FLOOR, 3, peak magnitudes below this value report level 0.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  meter active; low = hold in idle.
- sample_valid  in  1  one-cycle strobe; `sample` is accepted on any clk edge where it is high.
- sample  in  SAMPLE_W  raw mic sample.
- volume  out  5  current level, 0..16.
- volume_valid  out  1  one-cycle pulse when `volume` is updated.
- peak  out  SAMPLE_W-1  peak magnitude of the last completed window.

Behaviour:
- Reset (async, rst_n low):
  - volume=0, volume_valid=0, peak=0.
  - Window counter=0, running peak=0, state=IDLE.
- States:
  - IDLE: enters ACCUM when enable=1 (next edge).
  - ACCUM: accumulates samples.
  - Leaving ACCUM: enable=0 in any state returns to IDLE next edge.
  - Entering IDLE clears the counter and running peak.
  - volume/peak are held, not cleared, when entering IDLE.
- Magnitude:
  - mag = |sample - midscale|, computed in SAMPLE_W+1 signed bits.
  - The result 2^(SAMPLE_W-1) (sample=0) clamps to 2^(SAMPLE_W-1)-1.
  - Width is SAMPLE_W-1 bits.
- Accumulation (ACCUM, sample_valid=1): running peak = max(running peak, mag); counter increments.
- Window end:
  - Occurs on the accepted sample where counter == WINDOW-1. That sample is included in the closing window.
  - On that same edge:
    - counter <= 0.
    - running peak <= 0; the next window starts empty.
    - peak <= final max.
  - On the following edge:
    - volume updates.
    - volume_valid=1 for exactly one cycle.
  - Latency: 2 edges from the last accepted sample to volume_valid observed high.
- Quantisation (SAMPLE_W=12):
  - level = 0 if peak < NOISE_FLOOR.
  - Otherwise level = 1 + (peak >> 7), giving a maximum of 1+15 = 16.
  - General form: shift by SAMPLE_W-5.
- sample_valid pulses arriving in IDLE, or in the cycle enable falls, are ignored.
- Back-to-back sample_valid (every cycle) is fully supported; no sample is dropped, including at a window boundary.
- enable falling while a volume update is pending: the pending update still completes.
- rst_n asserted mid-window: all state clears immediately; no volume_valid is issued for the partial window.

Optional Feature:
- Macro MIC_VOLUME_DECAY_EN.
- Defined: at each window end, volume <= max(level, volume-1), saturating at 0. The display falls by at most 1 per window (peak-hold decay); rises are immediate.
- Undefined: volume <= level directly.
- peak output and volume_valid timing are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with random sample traffic -> volume=0, peak=0, volume_valid never high; release, enable=1 -> first volume_valid only after WINDOW accepted samples.
- WINDOW=4; samples 2048, 2348, 1048, 2048 -> peak=1000, volume=8, single volume_valid pulse 2 edges after the 4th strobe.
- NOISE_FLOOR=3, WINDOW=4; samples 2050, 2046, 2048, 2049 (peak 2) -> volume=0; then a window containing 2051 (peak 3) -> volume=1.
- Extremes, WINDOW=2:
  - Samples 0 then 2048 -> peak=2047, volume=16.
  - Samples 4095 then 2048 -> peak=2047, volume=16.
  - Continuous every-cycle sample_valid across 3 windows -> exactly 3 volume_valid pulses, none missed.
- enable dropped after 2 of 4 samples, re-raised, then 4 samples of peak 1000 -> volume=8 computed only from the new 4; no pulse for the partial window.
- Decay: window at volume=16, then windows of 2048 only -> with MIC_VOLUME_DECAY_EN: 15, 14, 13...; without: 0 immediately.

Source files
------------

// File: rtl/mic_volume_meter_if.sv
// ============================================================================
// Module   : mic_volume_meter_if
// Brief    : Sample-in / level-out bundle between the mic front end and meter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mic_volume_meter_if #(
  parameter int SAMPLE_W = 12
) ();
  logic                  enable;
  logic                  sample_valid;
  logic [SAMPLE_W-1:0]   sample;
  logic [4:0]            volume;
  logic                  volume_valid;
  logic [SAMPLE_W-2:0]   peak;

  modport master (
    output enable,
    output sample_valid,
    output sample,
    input  volume,
    input  volume_valid,
    input  peak
  );

  modport slave (
    input  enable,
    input  sample_valid,
    input  sample,
    output volume,
    output volume_valid,
    output peak
  );
endinterface

`default_nettype wire

// File: rtl/mic_volume_meter.sv
// ============================================================================
// Module   : mic_volume_meter
// Brief    : Windowed peak-magnitude meter producing a 0..16 volume level.
//            Optional build macro MIC_VOLUME_DECAY_EN enables peak-hold decay.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mic_volume_meter #(
  parameter int SAMPLE_W    = 12,
  parameter int WINDOW      = 2000,
  parameter int NOISE_FLOOR = 3
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  mic_volume_meter_if.slave   bus
);

  localparam int c_MAG_W = SAMPLE_W - 1;
  localparam int c_CNT_W = 16;
  localparam int c_SHIFT = SAMPLE_W - 5;

  localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(WINDOW - 1);
  localparam logic [c_MAG_W-1:0]  c_FLOOR = c_MAG_W'(NOISE_FLOOR);
  localparam logic [c_MAG_W-1:0]  c_MAGMAX = {c_MAG_W{1'b1}};
  localparam logic signed [SAMPLE_W:0] c_MID = (SAMPLE_W+1)'(1) <<< (SAMPLE_W - 1);

  localparam logic [0:0] c_S_IDLE  = 1'b0;
  localparam logic [0:0] c_S_ACCUM = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q;
  logic [c_MAG_W-1:0]   run_q;
  logic [c_MAG_W-1:0]   peak_q;
  logic                 pend_q;
  logic [4:0]           vol_q;
  logic                 vv_q;

  logic                 accept_w;
  logic                 clear_w;
  logic                 win_end_w;
  logic signed [SAMPLE_W:0] diff_w;
  logic [SAMPLE_W:0]    abs_w;
  logic [c_MAG_W-1:0]   mag_w;
  logic [c_MAG_W-1:0]   max_w;
  logic [4:0]           level_w;
  logic [4:0]           vol_next_w;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_S_IDLE:  if (bus.enable)  state_d = c_S_ACCUM;
      c_S_ACCUM: if (!bus.enable) state_d = c_S_IDLE;
      default:   state_d = c_S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // A strobe in the cycle enable falls is dropped, since the FSM is leaving ACCUM.
  always_comb begin
    accept_w  = (state_q == c_S_ACCUM) && bus.enable && bus.sample_valid;
    clear_w   = !bus.enable;
    win_end_w = accept_w && (cnt_q == c_LAST);
  end

  // Magnitude about midscale; the single out-of-range case (sample = 0) saturates.
  always_comb begin
    diff_w = $signed({1'b0, bus.sample}) - c_MID;
    abs_w  = (diff_w < 0) ? $unsigned(-diff_w) : $unsigned(diff_w);
    if (abs_w[SAMPLE_W:SAMPLE_W-1] != 2'b00) begin
      mag_w = c_MAGMAX;
    end else begin
      mag_w = abs_w[c_MAG_W-1:0];
    end
    max_w = (mag_w > run_q) ? mag_w : run_q;
  end

  always_comb begin
    if (peak_q < c_FLOOR) begin
      level_w = 5'd0;
    end else begin
      level_w = {1'b0, peak_q[c_MAG_W-1:c_SHIFT]} + 5'd1;
    end
  end

`ifdef MIC_VOLUME_DECAY_EN
  logic [4:0] decay_w;
  always_comb begin
    decay_w    = (vol_q == 5'd0) ? 5'd0 : (vol_q - 5'd1);
    vol_next_w = (level_w > decay_w) ? level_w : decay_w;
  end
`else
  always_comb begin
    vol_next_w = level_w;
  end
`endif

  // Window accumulation; peak is captured on the closing edge, volume one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      run_q  <= '0;
      peak_q <= '0;
      pend_q <= 1'b0;
      vol_q  <= 5'd0;
      vv_q   <= 1'b0;
    end else begin
      if (clear_w) begin
        cnt_q <= '0;
        run_q <= '0;
      end else if (accept_w) begin
        if (win_end_w) begin
          cnt_q  <= '0;
          run_q  <= '0;
          peak_q <= max_w;
        end else begin
          cnt_q <= cnt_q + 1'b1;
          run_q <= max_w;
        end
      end
      pend_q <= win_end_w;
      vv_q   <= pend_q;
      if (pend_q) begin
        vol_q <= vol_next_w;
      end
    end
  end

  assign bus.volume       = vol_q;
  assign bus.volume_valid = vv_q;
  assign bus.peak         = peak_q;

endmodule

`default_nettype wire

// File: tb/tb_mic_volume_meter.sv
// ============================================================================
// Module   : tb_mic_volume_meter
// Brief    : Scoreboard bench for mic_volume_meter (WINDOW=4 and WINDOW=2 DUTs).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mic_volume_meter;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  longint cyc   = 0;
  int     n_checks = 0;
  int     n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mic_volume_meter_if #(.SAMPLE_W(12)) ia ();
  mic_volume_meter_if #(.SAMPLE_W(12)) ib ();

  mic_volume_meter #(.SAMPLE_W(12), .WINDOW(4), .NOISE_FLOOR(3)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia)
  );

  mic_volume_meter #(.SAMPLE_W(12), .WINDOW(2), .NOISE_FLOOR(3)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib)
  );

  typedef struct {
    int     vol;
    int     pk;
    longint due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   rp[2];
  int   cnt[2];
  int   mv[2];
  int   win[2];

  function automatic int mag_of(input int s);
    int d;
    d = s - 2048;
    if (d < 0) d = -d;
    if (d > 2047) d = 2047;
    return d;
  endfunction

  function automatic int level_of(input int pk);
    if (pk < 3) return 0;
    return 1 + pk / 128;
  endfunction

  function automatic int next_vol(input int lvl, input int v);
    int dec;
`ifdef MIC_VOLUME_DECAY_EN
    dec = (v > 0) ? v - 1 : 0;
    return (lvl > dec) ? lvl : dec;
`else
    dec = v;
    return lvl;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rp[i] = 0; cnt[i] = 0; mv[i] = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One strobe; consecutive calls give an unbroken every-cycle stream.
  task automatic send(input int sel, input int s, input bit acc);
    exp_t e;
    int   m;
    if (sel == 0) begin
      ia.sample_valid = 1'b1; ia.sample = s[11:0];
    end else begin
      ib.sample_valid = 1'b1; ib.sample = s[11:0];
    end
    @(posedge clk);
    #1;
    if (acc) begin
      m = mag_of(s);
      if (m > rp[sel]) rp[sel] = m;
      cnt[sel]++;
      if (cnt[sel] == win[sel]) begin
        mv[sel] = next_vol(level_of(rp[sel]), mv[sel]);
        e.vol = mv[sel];
        e.pk  = rp[sel];
        e.due = cyc + 1;
        if (sel == 0) qa.push_back(e); else qb.push_back(e);
        rp[sel]  = 0;
        cnt[sel] = 0;
      end
    end
    if (sel == 0) ia.sample_valid = 1'b0; else ib.sample_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 12 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: pending a=%0d b=%0d, required 0", name, qa.size(), qb.size());
    end
  endtask

  // Scoreboard: each volume_valid pulse must match the oldest expected update.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ia.volume_valid) begin
      n_checks++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL dutA unexpected volume_valid: volume=%0d peak=%0d cyc=%0d", ia.volume, ia.peak, cyc);
      end else begin
        e = qa.pop_front();
        if (ia.volume !== 5'(e.vol) || ia.peak !== 11'(e.pk) || cyc != e.due) begin
          n_fail++;
          $display("FAIL dutA update: volume=%0d peak=%0d cyc=%0d, required volume=%0d peak=%0d cyc=%0d",
                   ia.volume, ia.peak, cyc, e.vol, e.pk, e.due);
        end
      end
    end
    if (rst_n && ib.volume_valid) begin
      n_checks++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL dutB unexpected volume_valid: volume=%0d peak=%0d cyc=%0d", ib.volume, ib.peak, cyc);
      end else begin
        e = qb.pop_front();
        if (ib.volume !== 5'(e.vol) || ib.peak !== 11'(e.pk) || cyc != e.due) begin
          n_fail++;
          $display("FAIL dutB update: volume=%0d peak=%0d cyc=%0d, required volume=%0d peak=%0d cyc=%0d",
                   ib.volume, ib.peak, cyc, e.vol, e.pk, e.due);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    ia.enable = 1'b1;
    ib.enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ia.sample_valid = 1'($urandom_range(0, 1));
      ia.sample       = 12'($urandom_range(0, 4095));
      ib.sample_valid = 1'($urandom_range(0, 1));
      ib.sample       = 12'($urandom_range(0, 4095));
      @(negedge clk);
      n_checks++;
      if (ia.volume !== 5'd0 || ia.peak !== 11'd0 || ia.volume_valid !== 1'b0 ||
          ib.volume !== 5'd0 || ib.peak !== 11'd0 || ib.volume_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset outputs: a vol=%0d pk=%0d vv=%0b b vol=%0d pk=%0d vv=%0b, required all 0",
                 ia.volume, ia.peak, ia.volume_valid, ib.volume, ib.peak, ib.volume_valid);
      end
    end
    ia.sample_valid = 1'b0;
    ib.sample_valid = 1'b0;
    ib.enable = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    idle(1);
    for (int i = 0; i < 3; i++) send(0, int'($urandom_range(0, 4095)), 1'b1);
    idle(4);
    n_checks++;
    if (ia.volume !== 5'd0 || ia.peak !== 11'd0) begin
      n_fail++;
      $display("FAIL reset partial window: volume=%0d peak=%0d, required 0 0", ia.volume, ia.peak);
    end
    send(0, int'($urandom_range(0, 4095)), 1'b1);
    drain("reset_first_window");
  endtask

  task automatic test_basic_window();
    send(0, 2048, 1'b1);
    send(0, 2348, 1'b1);
    send(0, 1048, 1'b1);
    send(0, 2048, 1'b1);
    drain("basic");
  endtask

  task automatic test_noise_floor();
    send(0, 2050, 1'b1);
    send(0, 2046, 1'b1);
    send(0, 2048, 1'b1);
    send(0, 2049, 1'b1);
    drain("noise_peak2");
    send(0, 2048, 1'b1);
    send(0, 2051, 1'b1);
    send(0, 2048, 1'b1);
    send(0, 2047, 1'b1);
    drain("noise_peak3");
  endtask

  task automatic test_enable_drop();
    send(0, 548, 1'b1);
    send(0, 548, 1'b1);
    ia.enable = 1'b0;
    send(0, 0, 1'b0);
    rp[0] = 0;
    cnt[0] = 0;
    send(0, 0, 1'b0);
    send(0, 4095, 1'b0);
    ia.enable = 1'b1;
    send(0, 0, 1'b0);
    send(0, 2048, 1'b1);
    send(0, 2348, 1'b1);
    send(0, 1048, 1'b1);
    send(0, 2048, 1'b1);
    drain("enable_drop");
  endtask

  task automatic test_midwindow_reset();
    send(0, 4095, 1'b1);
    send(0, 0, 1'b1);
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (ia.volume !== 5'd0 || ia.peak !== 11'd0 || ia.volume_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midwindow reset: volume=%0d peak=%0d vv=%0b, required 0 0 0",
               ia.volume, ia.peak, ia.volume_valid);
    end
    idle(2);
    rst_n = 1'b1;
    model_reset();
    idle(1);
    idle(6);
    send(0, 2048, 1'b1);
    send(0, 2048, 1'b1);
    send(0, 2048, 1'b1);
    send(0, 2148, 1'b1);
    drain("after_midwindow_reset");
    ia.enable = 1'b0;
  endtask

  task automatic test_extremes();
    ib.enable = 1'b1;
    idle(1);
    send(1, 0, 1'b1);
    send(1, 2048, 1'b1);
    drain("extreme_low");
    send(1, 4095, 1'b1);
    send(1, 2048, 1'b1);
    drain("extreme_high");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) send(1, int'($urandom_range(0, 4095)), 1'b1);
    drain("back_to_back");
  endtask

  task automatic test_decay();
    send(1, 0, 1'b1);
    send(1, 2048, 1'b1);
    drain("decay_top");
    for (int w = 0; w < 4; w++) begin
      send(1, 2048, 1'b1);
      send(1, 2048, 1'b1);
      drain("decay_step");
    end
  endtask

  initial begin
    win[0] = 4;
    win[1] = 2;
    model_reset();
    ia.enable = 1'b0; ia.sample_valid = 1'b0; ia.sample = '0;
    ib.enable = 1'b0; ib.sample_valid = 1'b0; ib.sample = '0;
    test_reset();
    test_basic_window();
    test_noise_floor();
    test_enable_drop();
    test_midwindow_reset();
    test_extremes();
    test_back_to_back();
    test_decay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
